// File: rtl/pe_tree_acc.sv
// Dot-product PE: per-beat multiply, pipelined log2 adder tree, group accumulate, bias add.
// Define PE_SAT_EN for saturating (sticky) accumulation and bias add; otherwise sums wrap.
module pe_tree_acc #(
    parameter int NUM_ELE   = 8,
    parameter int ELE_BITS  = 8,
    parameter int OUT_BITS  = 32,
    parameter int BIAS_BITS = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_ELE*ELE_BITS-1:0]   act_in,
    input  logic [NUM_ELE*ELE_BITS-1:0]   ker_in,
    input  logic                          ker_signed,
    input  logic                          valid_in,
    input  logic                          final_in,
    input  logic [BIAS_BITS-1:0]          bias_in,
    output logic                          valid_out,
    output logic [OUT_BITS-1:0]           macb_out,
    output logic [OUT_BITS-1:0]           act_sum_out
);
    localparam int L  = $clog2(NUM_ELE);
    localparam int PW = 2*ELE_BITS + 2;
    localparam int TW = PW + L;
    localparam int DW = NUM_ELE*ELE_BITS;
`ifdef PE_SAT_EN
    localparam int SW = ((TW > OUT_BITS) ? TW : OUT_BITS) + 1;
`else
    localparam int SW = (TW > OUT_BITS) ? TW : OUT_BITS;
`endif

    logic [DW-1:0]        act_s0_reg, ker_s0_reg;
    logic                 sgn_s0_reg;
    logic [L+2:0]         vld_sr_reg, fin_sr_reg;
    logic [BIAS_BITS-1:0] bias_sr_reg [L+3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_s0_reg <= '0;
            ker_s0_reg <= '0;
            sgn_s0_reg <= 1'b0;
            vld_sr_reg <= '0;
            fin_sr_reg <= '0;
            for (int s = 0; s <= L+2; s++) bias_sr_reg[s] <= '0;
        end else begin
            act_s0_reg     <= valid_in ? act_in : '0;
            ker_s0_reg     <= valid_in ? ker_in : '0;
            sgn_s0_reg     <= ker_signed;
            vld_sr_reg     <= {vld_sr_reg[L+1:0], valid_in};
            fin_sr_reg     <= {fin_sr_reg[L+1:0], final_in};
            bias_sr_reg[0] <= bias_in;
            for (int s = 1; s <= L+2; s++) bias_sr_reg[s] <= bias_sr_reg[s-1];
        end
    end

    // Level 0 holds products and pairwise activation sums; the activation tree is
    // therefore one level ahead and its last level is a plain register for alignment.
    for (genvar gi = 0; gi <= L; gi++) begin : g_lvl
        localparam int MN  = NUM_ELE >> gi;
        localparam int MW  = PW + gi;
        localparam int AN  = (gi < L) ? (NUM_ELE >> (gi + 1)) : 1;
        localparam int AWL = ELE_BITS + 1 + gi;
        logic signed [MW-1:0] mac_reg [MN];
        logic [AWL-1:0]       act_reg [AN];

        if (gi == 0) begin : g_mul
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int j = 0; j < MN; j++) mac_reg[j] <= '0;
                    for (int j = 0; j < AN; j++) act_reg[j] <= '0;
                end else begin
                    for (int j = 0; j < MN; j++)
                        mac_reg[j] <= PW'($signed({1'b0, act_s0_reg[j*ELE_BITS +: ELE_BITS]})) *
                                      PW'($signed({sgn_s0_reg & ker_s0_reg[j*ELE_BITS + ELE_BITS - 1],
                                                   ker_s0_reg[j*ELE_BITS +: ELE_BITS]}));
                    for (int j = 0; j < AN; j++)
                        act_reg[j] <= AWL'(act_s0_reg[2*j*ELE_BITS +: ELE_BITS]) +
                                      AWL'(act_s0_reg[(2*j+1)*ELE_BITS +: ELE_BITS]);
                end
            end
        end else begin : g_add
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int j = 0; j < MN; j++) mac_reg[j] <= '0;
                end else begin
                    for (int j = 0; j < MN; j++)
                        mac_reg[j] <= MW'(g_lvl[gi-1].mac_reg[2*j]) + MW'(g_lvl[gi-1].mac_reg[2*j+1]);
                end
            end
            if (gi < L) begin : g_act_add
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        for (int j = 0; j < AN; j++) act_reg[j] <= '0;
                    end else begin
                        for (int j = 0; j < AN; j++)
                            act_reg[j] <= AWL'(g_lvl[gi-1].act_reg[2*j]) + AWL'(g_lvl[gi-1].act_reg[2*j+1]);
                    end
                end
            end else begin : g_act_pass
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) act_reg[0] <= '0;
                    else        act_reg[0] <= AWL'(g_lvl[gi-1].act_reg[0]);
                end
            end
        end
    end

`ifdef PE_SAT_EN
    function automatic logic ovf(input logic [SW-1:0] v);
        return v[SW-1:OUT_BITS-1] != {(SW-OUT_BITS+1){v[SW-1]}};
    endfunction
`endif

    function automatic logic [OUT_BITS-1:0] fit(input logic [SW-1:0] v);
`ifdef PE_SAT_EN
        if (ovf(v)) return {v[SW-1], {(OUT_BITS-1){~v[SW-1]}}};
`endif
        return v[OUT_BITS-1:0];
    endfunction

    logic signed [OUT_BITS-1:0] acc_reg, act_acc_reg, acc_base, act_base;
    logic                       restart_reg;
    logic [SW-1:0]              mac_sum_next, act_sum_next, macb_next;
`ifdef PE_SAT_EN
    logic                       acc_sat_reg;
`endif

    always_comb begin
        acc_base     = restart_reg ? '0 : acc_reg;
        act_base     = restart_reg ? '0 : act_acc_reg;
        mac_sum_next = SW'(acc_base) + SW'(g_lvl[L].mac_reg[0]);
        act_sum_next = SW'(act_base) + SW'(g_lvl[L].act_reg[0]);
        macb_next    = SW'(acc_reg) + SW'($signed(bias_sr_reg[L+2]));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg     <= '0;
            act_acc_reg <= '0;
            restart_reg <= 1'b1;
`ifdef PE_SAT_EN
            acc_sat_reg <= 1'b0;
`endif
        end else if (vld_sr_reg[L+1]) begin
            restart_reg <= fin_sr_reg[L+1];
            act_acc_reg <= fit(act_sum_next);
`ifdef PE_SAT_EN
            // Once clamped, the group sum is frozen until the next group starts.
            if (restart_reg || !acc_sat_reg) begin
                acc_reg     <= fit(mac_sum_next);
                acc_sat_reg <= ovf(mac_sum_next);
            end
`else
            acc_reg <= fit(mac_sum_next);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out   <= 1'b0;
            macb_out    <= '0;
            act_sum_out <= '0;
        end else begin
            valid_out <= vld_sr_reg[L+2] & fin_sr_reg[L+2];
            if (vld_sr_reg[L+2] & fin_sr_reg[L+2]) begin
                macb_out    <= fit(macb_next);
                act_sum_out <= act_acc_reg;
            end
        end
    end
endmodule

// File: tb/tb_pe_tree_acc.sv
// Bench for pe_tree_acc: a 32-bit and a 20-bit instance share stimulus and are checked
// every cycle against a beat-level arithmetic model scheduled LAT cycles ahead.
module tb_pe_tree_acc;
    localparam int N   = 8;
    localparam int E   = 8;
    localparam int LAT = 7;
    localparam int DEPTH = 1024;
`ifdef PE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] act_in = '0, ker_in = '0;
    logic        ker_signed = 1'b0, valid_in = 1'b0, final_in = 1'b0;
    logic [31:0] bias_in = '0;
    logic        v32, v20;
    logic [31:0] m32, a32;
    logic [19:0] m20, a20;

    always #5 clk = ~clk;

    pe_tree_acc dut32 (
        .clk(clk), .reset(reset), .act_in(act_in), .ker_in(ker_in), .ker_signed(ker_signed),
        .valid_in(valid_in), .final_in(final_in), .bias_in(bias_in),
        .valid_out(v32), .macb_out(m32), .act_sum_out(a32)
    );

    pe_tree_acc #(.OUT_BITS(20), .BIAS_BITS(20)) dut20 (
        .clk(clk), .reset(reset), .act_in(act_in), .ker_in(ker_in), .ker_signed(ker_signed),
        .valid_in(valid_in), .final_in(final_in), .bias_in(bias_in[19:0]),
        .valid_out(v20), .macb_out(m20), .act_sum_out(a20)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Model: scheduled expectations indexed by the cycle the output must appear.
    bit     exp_v   [DEPTH];
    longint exp_m32 [DEPTH];
    longint exp_a32 [DEPTH];
    longint exp_m20 [DEPTH];
    longint exp_a20 [DEPTH];
    longint acc32 = 0, acc20 = 0, as32 = 0, as20 = 0;
    bit     sat32 = 0, sat20 = 0, rs = 1;
    int     last_idx = 0;

    function automatic longint clampw(input longint s, input int w);
        longint hi, lo, r;
        hi = (longint'(1) << (w-1)) - 1;
        lo = -hi - 1;
        if (SAT) begin
            if (s > hi) return hi;
            if (s < lo) return lo;
            return s;
        end
        r = s & ((longint'(1) << w) - 1);
        if (r > hi) r = r - (longint'(1) << w);
        return r;
    endfunction

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic beat(input logic [63:0] a, input logic [63:0] k, input bit sg,
                        input bit fin, input longint bias);
        longint dot, asum, s, n;
        dot  = 0;
        asum = 0;
        for (int i = 0; i < N; i++) begin
            longint av, kv;
            av = longint'(a[i*E +: E]);
            kv = longint'(k[i*E +: E]);
            if (sg && kv >= 128) kv = kv - 256;
            dot  += av * kv;
            asum += av;
        end
        if (rs) begin
            acc32 = 0; acc20 = 0; as32 = 0; as20 = 0; sat32 = 0; sat20 = 0;
        end
        if (!(SAT && sat32)) begin
            s = acc32 + dot; n = clampw(s, 32);
            if (n != s) sat32 = 1;
            acc32 = n;
        end
        if (!(SAT && sat20)) begin
            s = acc20 + dot; n = clampw(s, 20);
            if (n != s) sat20 = 1;
            acc20 = n;
        end
        as32 = clampw(as32 + asum, 32);
        as20 = clampw(as20 + asum, 20);
        rs = fin;
        if (fin) begin
            last_idx = cyc + LAT;
            exp_v[last_idx]   = 1'b1;
            exp_m32[last_idx] = clampw(acc32 + bias, 32);
            exp_m20[last_idx] = clampw(acc20 + bias, 20);
            exp_a32[last_idx] = as32;
            exp_a20[last_idx] = as20;
        end
        act_in = a; ker_in = k; ker_signed = sg; valid_in = 1'b1; final_in = fin;
        bias_in = 32'(bias);
        @(posedge clk); #1;
    endtask

    // Idle beats carry junk data and final_in=1, all of which must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            act_in = {$urandom, $urandom}; ker_in = {$urandom, $urandom};
            bias_in = $urandom; valid_in = 1'b0; final_in = 1'b1; ker_signed = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b0;
        valid_in = 1'b0; final_in = 1'b0;
        for (int k = cyc; k < DEPTH; k++) exp_v[k] = 1'b0;
        rs = 1; acc32 = 0; acc20 = 0; as32 = 0; as20 = 0; sat32 = 0; sat20 = 0;
        repeat (n) begin @(posedge clk); #1; end
        reset = 1'b1;
    endtask

    longint hm32 = 0, ha32 = 0, hm20 = 0, ha20 = 0;
    always @(negedge clk) begin
        bit ev;
        ev = 1'b0;
        if (!reset) begin
            hm32 = 0; ha32 = 0; hm20 = 0; ha20 = 0;
        end else if (cyc < DEPTH && exp_v[cyc]) begin
            ev = 1'b1;
            hm32 = exp_m32[cyc]; ha32 = exp_a32[cyc];
            hm20 = exp_m20[cyc]; ha20 = exp_a20[cyc];
        end
        if (v32)
            $display("out cyc=%0d macb32=%0d act32=%0d macb20=%0d act20=%0d",
                     cyc, $signed(m32), $signed(a32), $signed(m20), $signed(a20));
        chk("valid32", longint'(v32), longint'(ev));
        chk("valid20", longint'(v20), longint'(ev));
        chk("macb32", longint'($signed(m32)), hm32);
        chk("act32", longint'($signed(a32)), ha32);
        chk("macb20", longint'($signed(m20)), hm20);
        chk("act20", longint'($signed(a20)), ha20);
    end

    int i1;
    initial begin
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        idle(2);

        // Single final beat
        beat(rep(8'd2), rep(8'd3), 1'b0, 1'b1, 10);
        chk("t1 model macb", exp_m32[last_idx], 58);
        chk("t1 model act", exp_a32[last_idx], 16);
        idle(8);

        // Signedness on back-to-back finals
        beat(rep(8'hFF), rep(8'hFF), 1'b1, 1'b1, 0);
        i1 = last_idx;
        beat(rep(8'hFF), rep(8'hFF), 1'b0, 1'b1, 0);
        chk("t2 model signed", exp_m32[i1], -2040);
        chk("t2 model unsigned", exp_m32[last_idx], 520200);
        chk("t2 model unsigned20", exp_m20[last_idx], 520200);
        idle(8);

        // Multi-beat group with a gap, then restart
        beat(rep(8'd1), rep(8'd1), 1'b0, 1'b0, 123);
        beat(rep(8'd1), rep(8'd1), 1'b0, 1'b0, -77);
        idle(1);
        beat(rep(8'd1), rep(8'd1), 1'b0, 1'b1, -5);
        chk("t3 model macb", exp_m32[last_idx], 19);
        chk("t3 model act", exp_a32[last_idx], 24);
        beat(rep(8'd1), rep(8'd1), 1'b0, 1'b1, 0);
        chk("t3 model restart", exp_m32[last_idx], 8);
        idle(8);

        // Overflow of the 20-bit instance
        beat(rep(8'hFF), rep(8'hFF), 1'b0, 1'b0, 0);
        beat(rep(8'hFF), rep(8'hFF), 1'b0, 1'b1, 0);
        chk("t4 model macb32", exp_m32[last_idx], 1040400);
        chk("t4 model macb20", exp_m20[last_idx], SAT ? 524287 : -8176);
        idle(8);

        // Negative overflow then a positive beat: sticky clamp vs wrap
        repeat (3) beat(rep(8'hFF), rep(8'h80), 1'b1, 1'b0, 0);
        beat(rep(8'hFF), rep(8'h7F), 1'b1, 1'b1, 0);
        chk("t6 model macb32", exp_m32[last_idx], -524280);
        chk("t6 model macb20", exp_m20[last_idx], SAT ? -524288 : -524280);
        chk("t6 model act20", exp_a20[last_idx], 8160);
        idle(8);

        // Mixed per-element data
        beat(64'h07_25_43_61_7F_9D_BB_D9, 64'h81_7F_00_FE_10_C3_05_99, 1'b1, 1'b1, -1000);
        beat(64'h07_25_43_61_7F_9D_BB_D9, 64'h81_7F_00_FE_10_C3_05_99, 1'b0, 1'b1, 77);
        idle(8);

        // Reset mid-group
        beat(rep(8'd5), rep(8'd5), 1'b0, 1'b0, 0);
        beat(rep(8'd5), rep(8'd5), 1'b0, 1'b0, 0);
        pulse_reset(2);
        beat(rep(8'd1), rep(8'd2), 1'b0, 1'b1, 0);
        chk("t5 model macb", exp_m32[last_idx], 16);
        chk("t5 model act", exp_a32[last_idx], 8);
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
